// File: rtl/cpu_cmd_sequencer.sv
// Host-to-CPU command sequencer: FIFO-buffers commands, issues them under the cpu_rdy handshake
// and holds one result for the host. Define SEQ_WATCHDOG_EN to build the busy/ready watchdog.
module cpu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int BUSY_TO = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [6:0]           host_cmd,
    input  logic [4*WIDTH-1:0]   host_data,
    output logic [6:0]           cmd_in,
    output logic [WIDTH-1:0]     din_1,
    output logic [WIDTH-1:0]     din_2,
    output logic [WIDTH-1:0]     din_3,
    output logic [WIDTH-1:0]     din_4,
    input  logic                 cpu_rdy,
    input  logic [2*WIDTH-1:0]   out_reg3,
    input  logic                 zero,
    input  logic                 error,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_data,
    output logic [2:0]           res_flags,
    output logic                 busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 7 + 4*WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_RDY, CAPTURE} state_t;

    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [EW-1:0]   head;
    logic            push;
    logic            pop;
    logic            timed_out;
    logic            wd_expired;

    assign host_ready = (count != FULL_CNT);
    assign push       = host_valid && host_ready && (host_cmd != 7'd0);
    // An empty FIFO forwards the incoming beat so a lone command issues on the next cycle.
    assign pop        = (state == IDLE) && cpu_rdy && (!res_valid || res_ready)
                        && ((count != '0) || push);
    assign head       = (count == '0) ? {host_cmd, host_data} : mem[rd_ptr];
    assign busy       = (state != IDLE) || (count != '0);

    // NOTE: storage carries no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {host_cmd, host_data};
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int TW = $clog2(BUSY_TO + 1);
    logic [TW-1:0] wd_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= '0;
        else if (state == ISSUE)
            wd_cnt <= '0;
        else if ((state == WAIT_BUSY) || (state == WAIT_RDY))
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expired = (wd_cnt == TW'(BUSY_TO - 1));
`else
    // Without the watchdog the FSM waits on the CPU indefinitely.
    assign wd_expired = (BUSY_TO < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_in    <= '0;
            din_1     <= '0;
            din_2     <= '0;
            din_3     <= '0;
            din_4     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
            timed_out <= 1'b0;
        end else begin
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd_in    <= head[EW-1:4*WIDTH];
                        din_1     <= head[WIDTH-1:0];
                        din_2     <= head[2*WIDTH-1:WIDTH];
                        din_3     <= head[3*WIDTH-1:2*WIDTH];
                        din_4     <= head[4*WIDTH-1:3*WIDTH];
                        timed_out <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_in <= '0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!cpu_rdy) begin
                        state <= WAIT_RDY;
                    end else if (wd_expired) begin
                        timed_out <= 1'b1;
                        state     <= CAPTURE;
                    end
                end
                WAIT_RDY: begin
                    if (cpu_rdy) begin
                        state <= CAPTURE;
                    end else if (wd_expired) begin
                        timed_out <= 1'b1;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    res_valid <= 1'b1;
                    res_data  <= timed_out ? '0 : out_reg3;
                    res_flags <= timed_out ? 3'b100 : {1'b0, error, zero};
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
